// File: rtl/dp_ram_fifo_ctrl.sv
// Synchronous FIFO controller that drives a 16x8 dual-port RAM.
// Writes use RAM port A, reads use port B. pop_data returns one cycle after an accepted pop.
module dp_ram_fifo_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    input  logic              clr_err,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_add_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_re_b,
    output logic [ADDR_W-1:0] ram_add_b,
    input  logic [DATA_W-1:0] ram_out_b
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              push_ok, pop_ok;
    logic              overflow_nxt, underflow_nxt;

    // Accept decisions use registered status only; strobes are held low during reset.
    always_comb begin
        push_ok       = push & ~full  & ~flush & ~rst;
        pop_ok        = pop  & ~empty & ~flush & ~rst;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        count_nxt     = count;
        overflow_nxt  = overflow  & ~clr_err;
        underflow_nxt = underflow & ~clr_err;

        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is 2**ADDR_W.
            wr_ptr_nxt = wr_ptr + ADDR_W'(push_ok);
            rd_ptr_nxt = rd_ptr + ADDR_W'(pop_ok);
            case ({push_ok, pop_ok})
                2'b10:   count_nxt = count + CNT_W'(1);
                2'b01:   count_nxt = count - CNT_W'(1);
                default: count_nxt = count;
            endcase
        end

        if (push & full & ~flush)
            overflow_nxt = 1'b1;
        if (pop & empty & ~flush)
            underflow_nxt = 1'b1;
    end

    assign ram_we_a   = push_ok;
    assign ram_add_a  = wr_ptr;
    assign ram_data_a = push_data;
    assign ram_re_b   = pop_ok;
    assign ram_add_b  = rd_ptr;
    assign pop_data   = ram_out_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            empty     <= (count_nxt == '0);
            full      <= (count_nxt == CNT_W'(DEPTH));
            pop_valid <= pop_ok;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Directed bench for dp_ram_fifo_ctrl with a behavioural 16x8 dual-port RAM attached.
module tb_dp_ram_fifo_ctrl;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic       push, pop, flush, clr_err;
    logic [7:0] push_data, pop_data;
    logic       pop_valid, full, empty, overflow, underflow;
    logic [4:0] count;
    logic       ram_we_a, ram_re_b;
    logic [3:0] ram_add_a, ram_add_b;
    logic [7:0] ram_data_a, ram_out_b;

    logic [7:0] mem [16];
    logic       ff_written = 1'b0;

    int checks   = 0;
    int failures = 0;
    int max_cnt;

    dp_ram_fifo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .flush      (flush),
        .clr_err    (clr_err),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow),
        .ram_we_a   (ram_we_a),
        .ram_add_a  (ram_add_a),
        .ram_data_a (ram_data_a),
        .ram_re_b   (ram_re_b),
        .ram_add_b  (ram_add_b),
        .ram_out_b  (ram_out_b)
    );

    always #5 clk = ~clk;

    // RAM model: write on we_a edge, registered read on re_b edge.
    always @(posedge clk) begin
        if (ram_we_a) begin
            mem[ram_add_a] <= ram_data_a;
            if (ram_data_a == 8'hFF) ff_written <= 1'b1;
        end
        if (ram_re_b) ram_out_b <= mem[ram_add_b];
    end

    typedef struct {
        logic       push;
        logic [7:0] pd;
        logic       pop;
        logic       flush;
        logic       clr;
        logic       we;
        logic [3:0] add;
        logic [4:0] cnt;
        logic       emp;
        logic       ful;
        logic       pv;
        logic [7:0] pdata;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic drive(input logic p, input logic [7:0] d, input logic q,
                         input logic f, input logic c);
        @(negedge clk);
        push = p; push_data = d; pop = q; flush = f; clr_err = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{Y, 8'hA1, N, N, N, Y, 4'd0, 5'd1, N, N, N, 8'h00, N, N};
        vecs[1]  = '{Y, 8'hB2, N, N, N, Y, 4'd1, 5'd2, N, N, N, 8'h00, N, N};
        vecs[2]  = '{Y, 8'hC3, N, N, N, Y, 4'd2, 5'd3, N, N, N, 8'h00, N, N};
        vecs[3]  = '{N, 8'h00, Y, N, N, N, 4'd0, 5'd2, N, N, Y, 8'hA1, N, N};
        vecs[4]  = '{N, 8'h00, Y, N, N, N, 4'd0, 5'd1, N, N, Y, 8'hB2, N, N};
        vecs[5]  = '{N, 8'h00, Y, N, N, N, 4'd0, 5'd0, Y, N, Y, 8'hC3, N, N};
        vecs[6]  = '{N, 8'h00, N, N, N, N, 4'd0, 5'd0, Y, N, N, 8'h00, N, N};
        vecs[7]  = '{Y, 8'h11, Y, N, N, Y, 4'd3, 5'd1, N, N, N, 8'h00, N, Y};
        vecs[8]  = '{N, 8'h00, N, N, Y, N, 4'd0, 5'd1, N, N, N, 8'h00, N, N};
        vecs[9]  = '{Y, 8'h22, N, N, N, Y, 4'd4, 5'd2, N, N, N, 8'h00, N, N};
        vecs[10] = '{Y, 8'h33, N, N, N, Y, 4'd5, 5'd3, N, N, N, 8'h00, N, N};
        vecs[11] = '{Y, 8'h44, N, N, N, Y, 4'd6, 5'd4, N, N, N, 8'h00, N, N};
        vecs[12] = '{Y, 8'h55, N, N, N, Y, 4'd7, 5'd5, N, N, N, 8'h00, N, N};
        vecs[13] = '{Y, 8'h66, Y, N, N, Y, 4'd8, 5'd5, N, N, Y, 8'h11, N, N};
        vecs[14] = '{N, 8'h00, Y, N, N, N, 4'd0, 5'd4, N, N, Y, 8'h22, N, N};
        vecs[15] = '{Y, 8'hAA, Y, Y, N, N, 4'd0, 5'd0, Y, N, N, 8'h00, N, N};
        vecs[16] = '{N, 8'h00, Y, N, Y, N, 4'd0, 5'd0, Y, N, N, 8'h00, N, Y};
        vecs[17] = '{N, 8'h00, N, N, Y, N, 4'd0, 5'd0, Y, N, N, 8'h00, N, N};
        vecs[18] = '{Y, 8'h77, N, N, N, Y, 4'd0, 5'd1, N, N, N, 8'h00, N, N};

        rst = 1'b1; push = 1'b1; push_data = 8'h99; pop = 1'b1; flush = 1'b0; clr_err = 1'b0;
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_pop_valid", 32'(pop_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_underflow", 32'(underflow), 0);
        chk("rst_we_a", 32'(ram_we_a), 0);
        chk("rst_re_b", 32'(ram_re_b), 0);
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        rst = 1'b0;

        // Table: basic push/pop, simultaneous ops, errors, flush
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].push, vecs[i].pd, vecs[i].pop, vecs[i].flush, vecs[i].clr);
            chk($sformatf("v%0d_we_a", i), 32'(ram_we_a), 32'(vecs[i].we));
            if (vecs[i].we) begin
                chk($sformatf("v%0d_add_a", i), 32'(ram_add_a), 32'(vecs[i].add));
                chk($sformatf("v%0d_data_a", i), 32'(ram_data_a), 32'(vecs[i].pd));
            end
            tick();
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].ful));
            chk($sformatf("v%0d_pop_valid", i), 32'(pop_valid), 32'(vecs[i].pv));
            if (vecs[i].pv)
                chk($sformatf("v%0d_pop_data", i), 32'(pop_data), 32'(vecs[i].pdata));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_underflow", i), 32'(underflow), 32'(vecs[i].unf));
        end

        // Fill to full, reject a 17th push, then drain in order
        drive(N, 8'h00, N, Y, N); tick();
        chk("fill_start_count", 32'(count), 0);
        for (int i = 0; i < 16; i++) begin
            drive(Y, 8'(i), N, N, N);
            chk($sformatf("fill%0d_add_a", i), 32'(ram_add_a), 32'(i));
            tick();
            chk($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
        end
        chk("fill_full", 32'(full), 1);
        drive(Y, 8'hFF, N, N, N);
        chk("ovf_we_a", 32'(ram_we_a), 0);
        tick();
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);
        for (int i = 0; i < 16; i++) begin
            drive(N, 8'h00, Y, N, N);
            chk($sformatf("drain%0d_add_b", i), 32'(ram_add_b), 32'(i));
            tick();
            chk($sformatf("drain%0d_pop_valid", i), 32'(pop_valid), 1);
            chk($sformatf("drain%0d_pop_data", i), 32'(pop_data), 32'(i));
        end
        drive(N, 8'h00, N, N, Y); tick();
        chk("drain_pop_valid_off", 32'(pop_valid), 0);
        chk("drain_empty", 32'(empty), 1);
        chk("ovf_cleared", 32'(overflow), 0);
        chk("ff_never_written", 32'(ff_written), 0);

        // Pointer wrap: second batch of 10 spans addresses 10..15, 0..3
        max_cnt = 0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 10; i++) begin
                drive(Y, 8'(8'h40 + 8'(b * 16 + i)), N, N, N);
                chk($sformatf("wrap%0d_%0d_add_a", b, i), 32'(ram_add_a), 32'((b * 10 + i) % 16));
                tick();
                if (int'(count) > max_cnt) max_cnt = int'(count);
            end
            for (int i = 0; i < 10; i++) begin
                drive(N, 8'h00, Y, N, N);
                tick();
                chk($sformatf("wrap%0d_%0d_pop_data", b, i), 32'(pop_data), 32'(8'h40 + 8'(b * 16 + i)));
            end
        end
        chk("wrap_max_count", 32'(max_cnt), 10);
        chk("wrap_empty", 32'(empty), 1);

        // Flush with 7 entries; next push goes to address 0
        for (int i = 0; i < 7; i++) begin
            drive(Y, 8'(8'h70 + 8'(i)), N, N, N); tick();
        end
        chk("pre_flush_count", 32'(count), 7);
        drive(N, 8'h00, N, Y, N); tick();
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        drive(Y, 8'h5A, N, N, N);
        chk("post_flush_add_a", 32'(ram_add_a), 0);
        tick();
        chk("post_flush_count", 32'(count), 1);

        // Asynchronous reset in the middle of a pop burst
        for (int i = 0; i < 3; i++) begin
            drive(Y, 8'(8'hE0 + 8'(i)), N, N, N); tick();
        end
        drive(N, 8'h00, Y, N, N); tick();
        chk("burst_pop_valid", 32'(pop_valid), 1);
        chk("burst_pop_data", 32'(pop_data), 8'h5A);
        drive(N, 8'h00, Y, N, N);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_pop_valid", 32'(pop_valid), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_re_b", 32'(ram_re_b), 0);
        @(negedge clk);
        rst = 1'b0; pop = 1'b0;
        tick();
        chk("arst_after_pop_valid", 32'(pop_valid), 0);
        chk("arst_after_count", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
